display_update_scheduler: RTL and testbench

//  Frame-synchronous controller that sequences every position/orientation/scale update into the VGA writer datapath.

---
 rtl/display_update_scheduler_pkg.sv | 38 +++
 rtl/display_update_scheduler_if.sv | 34 +++
 rtl/display_update_scheduler_target_position_lut.sv | 34 +++
 rtl/display_update_scheduler.sv | 164 ++++++++++++++++
 tb/tb_display_update_scheduler.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/display_update_scheduler_pkg.sv
// Shared constants for the display update path: grid geometry, target slot
// spacing, scale thresholds, FSM encoding and the rover sample record.
package display_update_scheduler_pkg;

  localparam int GRID_BOTTOM_BORDER_D = 256;
  localparam int GRID_TOP_BORDER_D    = 512;
  localparam int GRID_RIGHT_BORDER_D  = 256;
  localparam int SCALE_DEFAULT_D      = 2;

  // Target rows 1 and 2 sit this far above the grid baseline, in steps.
  localparam int TGT_Y_STEP = 64;

  // Auto-scale: largest magnification that keeps the rover on the grid.
  localparam int SCALE4_LIM = 64;
  localparam int SCALE2_LIM = 128;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SNAP   = 3'd1;
  localparam logic [2:0] ST_SCALE  = 3'd2;
  localparam logic [2:0] ST_MULT   = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;

  typedef struct packed {
    logic signed [8:0] x;
    logic signed [8:0] y;
    logic [4:0]        o;
  } rover_sample_t;

  // Scale factors are powers of two; anything else is treated as 1.
  function automatic logic [1:0] scale_shift(input logic [2:0] s);
    case (s)
      3'd4:    return 2'd2;
      3'd2:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/display_update_scheduler_if.sv
// Rover update inputs and committed draw-state outputs of the scheduler.
interface display_update_scheduler_if;
  logic              vsync;
  logic signed [8:0] rover_x_in;
  logic signed [8:0] rover_y_in;
  logic              new_data;
  logic [4:0]        orientation_in;
  logic              orientation_ready;
  logic [3:0]        target_location;

  logic signed [11:0] rover_x;
  logic signed [11:0] rover_y;
  logic signed [11:0] target_x;
  logic signed [11:0] target_y;
  logic [4:0]         orientation;
  logic               oriented;
  logic [2:0]         scale;
  logic               commit;
  logic               busy;

  modport master (
    output vsync, rover_x_in, rover_y_in, new_data, orientation_in,
           orientation_ready, target_location,
    input  rover_x, rover_y, target_x, target_y, orientation, oriented,
           scale, commit, busy
  );

  modport slave (
    input  vsync, rover_x_in, rover_y_in, new_data, orientation_in,
           orientation_ready, target_location,
    output rover_x, rover_y, target_x, target_y, orientation, oriented,
           scale, commit, busy
  );
endinterface

// File: rtl/display_update_scheduler_target_position_lut.sv
// Switch-selected target slot to signed screen coordinates.
// Columns: centre-right, centre, left edge, right edge.
// Rows: baseline, two intermediate steps, grid top.
module target_position_lut
  import display_update_scheduler_pkg::*;
#(
  parameter int GRID_BOTTOM_BORDER = GRID_BOTTOM_BORDER_D,
  parameter int GRID_TOP_BORDER    = GRID_TOP_BORDER_D,
  parameter int GRID_RIGHT_BORDER  = GRID_RIGHT_BORDER_D
) (
  input  logic [3:0]         target_location,
  output logic signed [11:0] target_x,
  output logic signed [11:0] target_y
);

  // Pure decode; consumers register the result themselves.
  always_comb begin
    target_x = '0;
    target_y = 12'(GRID_BOTTOM_BORDER);
    case (target_location[1:0])
      2'd0: target_x = 12'(GRID_RIGHT_BORDER / 2);
      2'd1: target_x = '0;
      2'd2: target_x = 12'(-GRID_RIGHT_BORDER);
      2'd3: target_x = 12'(GRID_RIGHT_BORDER);
    endcase
    case (target_location[3:2])
      2'd0: target_y = 12'(GRID_BOTTOM_BORDER);
      2'd1: target_y = 12'(GRID_BOTTOM_BORDER + TGT_Y_STEP);
      2'd2: target_y = 12'(GRID_BOTTOM_BORDER + 2 * TGT_Y_STEP);
      2'd3: target_y = 12'(GRID_TOP_BORDER);
    endcase
  end

endmodule

// File: rtl/display_update_scheduler.sv
// Frame-synchronous commit of rover position/orientation/scale and target
// position. Updates arrive at any rate into shadow registers; once per frame,
// on the vsync falling edge, a short FSM snapshots them, picks a scale,
// maps to screen space and updates every output in the same cycle.
module display_update_scheduler
  import display_update_scheduler_pkg::*;
#(
  parameter int GRID_BOTTOM_BORDER = GRID_BOTTOM_BORDER_D,
  parameter int GRID_TOP_BORDER    = GRID_TOP_BORDER_D,
  parameter int GRID_RIGHT_BORDER  = GRID_RIGHT_BORDER_D,
  parameter bit AUTO_SCALE         = 1'b1,
  parameter int SCALE_DEFAULT      = SCALE_DEFAULT_D
) (
  input  logic                       vclock,
  input  logic                       reset,
  display_update_scheduler_if.slave  bus
);

  logic [2:0]         state;
  logic               vsync_d;
  logic               start;
  rover_sample_t      sh;
  rover_sample_t      wk;
  logic               pend_loc, pend_ori;
  logic               take_loc, take_ori;
  logic [3:0]         tl_w;
  logic [9:0]         ax, ay;
  logic [9:0]         ax_c, ay_c;
  logic signed [9:0]  sx_ext, sy_ext;
  logic [2:0]         scale_w;
  logic [1:0]         sh_amt;
  logic signed [11:0] x12;
  logic signed [11:0] wx_c, wy_c;
  logic signed [11:0] tx_c, ty_c;

  // Falling edge of active-low vsync marks the start of vertical blanking.
  always_ff @(posedge vclock) begin
    if (reset) vsync_d <= 1'b0;
    else       vsync_d <= bus.vsync;
  end

  assign start = vsync_d & ~bus.vsync;

  // Shadow capture runs in every state; a pulse landing on the SNAP cycle
  // overrides the flag clear and so stays pending for the next frame.
  always_ff @(posedge vclock) begin
    if (reset) begin
      sh       <= '0;
      pend_loc <= 1'b0;
      pend_ori <= 1'b0;
    end else begin
      if (state == ST_SNAP) begin
        pend_loc <= 1'b0;
        pend_ori <= 1'b0;
      end
      if (bus.new_data) begin
        sh.x     <= bus.rover_x_in;
        sh.y     <= bus.rover_y_in;
        pend_loc <= 1'b1;
      end
      if (bus.orientation_ready) begin
        sh.o     <= bus.orientation_in;
        pend_ori <= 1'b1;
      end
    end
  end

  // Magnitudes for the scale decision; negative y is clamped to the baseline.
  always_comb begin
    sx_ext = {sh.x[8], sh.x};
    sy_ext = {sh.y[8], sh.y};
    ax_c   = sx_ext[9] ? $unsigned(-sx_ext) : $unsigned(sx_ext);
    ay_c   = sy_ext[9] ? 10'd0 : $unsigned(sy_ext);
  end

  // Sequencer: one cycle per step, edges seen while busy are dropped.
  always_ff @(posedge vclock) begin
    if (reset) begin
      state    <= ST_IDLE;
      wk       <= '0;
      take_loc <= 1'b0;
      take_ori <= 1'b0;
      tl_w     <= '0;
      ax       <= '0;
      ay       <= '0;
      scale_w  <= 3'(SCALE_DEFAULT);
    end else begin
      case (state)
        ST_IDLE: if (start) state <= ST_SNAP;
        ST_SNAP: begin
          wk       <= sh;
          take_loc <= pend_loc;
          take_ori <= pend_ori;
          tl_w     <= bus.target_location;
          ax       <= ax_c;
          ay       <= ay_c;
          state    <= ST_SCALE;
        end
        ST_SCALE: begin
          // Uses the latest position even if no new sample arrived.
          if (!AUTO_SCALE)
            scale_w <= 3'(SCALE_DEFAULT);
          else if (ax <= 10'(SCALE4_LIM) && ay <= 10'(SCALE4_LIM))
            scale_w <= 3'd4;
          else if (ax <= 10'(SCALE2_LIM) && ay <= 10'(SCALE2_LIM))
            scale_w <= 3'd2;
          else
            scale_w <= 3'd1;
          state <= ST_MULT;
        end
        ST_MULT:   state <= ST_COMMIT;
        ST_COMMIT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Screen mapping as shifts; thresholds guarantee |wx|<=256, wy in [256,512].
  always_comb begin
    sh_amt = scale_shift(scale_w);
    x12    = {{3{wk.x[8]}}, wk.x};
    wx_c   = x12 <<< sh_amt;
    wy_c   = $signed(({2'b00, ay} << sh_amt) + 12'(GRID_BOTTOM_BORDER));
  end

  target_position_lut #(
    .GRID_BOTTOM_BORDER (GRID_BOTTOM_BORDER),
    .GRID_TOP_BORDER    (GRID_TOP_BORDER),
    .GRID_RIGHT_BORDER  (GRID_RIGHT_BORDER)
  ) u_tgt (
    .target_location (tl_w),
    .target_x        (tx_c),
    .target_y        (ty_c)
  );

  // Outputs load on the MULT->COMMIT edge so the new values and the commit
  // pulse appear together in the COMMIT cycle, inside vertical blanking.
  always_ff @(posedge vclock) begin
    if (reset) begin
      bus.rover_x     <= '0;
      bus.rover_y     <= 12'(GRID_BOTTOM_BORDER);
      bus.target_x    <= 12'(GRID_RIGHT_BORDER / 2);
      bus.target_y    <= 12'(GRID_BOTTOM_BORDER);
      bus.orientation <= '0;
      bus.oriented    <= 1'b0;
      bus.scale       <= 3'(SCALE_DEFAULT);
    end else if (state == ST_MULT) begin
      bus.rover_x     <= wx_c;
      bus.rover_y     <= wy_c;
      bus.target_x    <= tx_c;
      bus.target_y    <= ty_c;
      bus.orientation <= wk.o;
      bus.scale       <= scale_w;
      // Fresh heading draws a triangle; a move without one means the
      // heading is stale, so fall back to the square.
      if (take_ori)      bus.oriented <= 1'b1;
      else if (take_loc) bus.oriented <= 1'b0;
    end
  end

  assign bus.commit = (state == ST_COMMIT);
  assign bus.busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_display_update_scheduler.sv
// Bench for display_update_scheduler: a frame-level reference model checked
// every cycle, plus hand-computed expectations for the directed scenarios.
module tb_display_update_scheduler;

  logic vclock = 1'b0;
  logic reset;
  display_update_scheduler_if bus ();

  display_update_scheduler dut (
    .vclock (vclock),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 vclock = ~vclock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int sh_x, sh_y, sh_o;
  bit pl, po;
  int w_x, w_y, w_o, w_tl;
  bit t_l, t_o;
  int cnt;          // 0 idle, 1 snapshot step, ... 4 commit cycle
  bit vprev;
  bit armed = 1'b0;
  int e_rx, e_ry, e_tx, e_ty, e_o, e_sc;
  bit e_or;
  int tx_tab [4] = '{128, 0, -256, 256};
  int ty_tab [4] = '{256, 320, 384, 512};

  task automatic model_reset();
    sh_x = 0; sh_y = 0; sh_o = 0; pl = 0; po = 0;
    w_x = 0; w_y = 0; w_o = 0; w_tl = 0; t_l = 0; t_o = 0;
    cnt = 0; vprev = 0;
    e_rx = 0; e_ry = 256; e_tx = 128; e_ty = 256; e_o = 0; e_or = 0; e_sc = 2;
  endtask

  task automatic model_commit();
    int ax, ay, s;
    ax = (w_x < 0) ? -w_x : w_x;
    ay = (w_y < 0) ? 0 : w_y;
    if (ax <= 64 && ay <= 64)        s = 4;
    else if (ax <= 128 && ay <= 128) s = 2;
    else                             s = 1;
    e_sc = s;
    e_rx = w_x * s;
    e_ry = ay * s + 256;
    e_tx = tx_tab[w_tl % 4];
    e_ty = ty_tab[w_tl / 4];
    e_o  = w_o;
    if (t_o)      e_or = 1;
    else if (t_l) e_or = 0;
  endtask

  always @(posedge vclock) begin
    if (reset) begin
      model_reset();
      armed = 1'b1;
    end else begin
      if (cnt == 1) begin
        w_x = sh_x; w_y = sh_y; w_o = sh_o; t_l = pl; t_o = po;
        w_tl = int'(bus.target_location);
        pl = 0; po = 0;
      end
      if (cnt == 3) model_commit();
      if (bus.new_data) begin
        sh_x = int'(bus.rover_x_in); sh_y = int'(bus.rover_y_in); pl = 1;
      end
      if (bus.orientation_ready) begin
        sh_o = int'(bus.orientation_in); po = 1;
      end
      if (cnt == 0) begin
        if (vprev && !bus.vsync) cnt = 1;
      end else begin
        cnt = (cnt == 4) ? 0 : cnt + 1;
      end
      vprev = bus.vsync;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge vclock) begin
    if (armed) begin
      n_tests++;
      if (bus.rover_x !== 12'(e_rx) || bus.rover_y !== 12'(e_ry) ||
          bus.target_x !== 12'(e_tx) || bus.target_y !== 12'(e_ty) ||
          bus.orientation !== 5'(e_o) || bus.oriented !== e_or ||
          bus.scale !== 3'(e_sc) || bus.commit !== (cnt == 4) ||
          bus.busy !== (cnt != 0)) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t got rx=%0d ry=%0d tx=%0d ty=%0d o=%0d or=%0b sc=%0d cm=%0b bz=%0b exp rx=%0d ry=%0d tx=%0d ty=%0d o=%0d or=%0b sc=%0d cm=%0b bz=%0b",
                 $time, bus.rover_x, bus.rover_y, bus.target_x, bus.target_y,
                 bus.orientation, bus.oriented, bus.scale, bus.commit, bus.busy,
                 e_rx, e_ry, e_tx, e_ty, e_o, e_or, e_sc, cnt == 4, cnt != 0);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Counts negedges until commit; bounded so a missing commit is a failure.
  task automatic wait_commit(output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge vclock);
      if (bus.commit === 1'b1) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      n_tests++; n_fail++;
      $display("FAIL commit_timeout got=none exp=commit within 20 cycles");
    end
  endtask

  task automatic restore_vsync();
    repeat (2) @(posedge vclock);
    #1 bus.vsync = 1'b1;
    repeat (3) @(posedge vclock);
    #1;
  endtask

  // Latency 5 negedges: the start cycle itself, then four more to commit.
  task automatic frame(input string nm);
    int lat;
    @(posedge vclock); #1 bus.vsync = 1'b0;
    wait_commit(lat);
    chk({nm, "_latency"}, lat, 5);
    chk({nm, "_rx"}, int'(bus.rover_x), e_rx);
  endtask

  task automatic pulse(input bit dl, input int x, input int y,
                       input bit dor, input int o);
    @(posedge vclock); #1;
    bus.new_data = dl; bus.rover_x_in = 9'(x); bus.rover_y_in = 9'(y);
    bus.orientation_ready = dor; bus.orientation_in = 5'(o);
    @(posedge vclock); #1;
    bus.new_data = 1'b0; bus.orientation_ready = 1'b0;
  endtask

  task automatic chk_rover(input string nm, input int sc, input int rx, input int ry);
    chk({nm, "_scale"}, int'(bus.scale), sc);
    chk({nm, "_rover_x"}, int'(bus.rover_x), rx);
    chk({nm, "_rover_y"}, int'(bus.rover_y), ry);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset = 1'b1;
    bus.vsync = 1'b1; bus.new_data = 1'b0; bus.orientation_ready = 1'b0;
    bus.rover_x_in = '0; bus.rover_y_in = '0; bus.orientation_in = '0;
    bus.target_location = 4'd0;
    repeat (3) @(posedge vclock);
    #1 reset = 1'b0;
    @(negedge vclock);
    chk("rst_rover_y", int'(bus.rover_y), 256);
    chk("rst_target_x", int'(bus.target_x), 128);
    chk("rst_scale", int'(bus.scale), 2);
    chk("rst_busy", int'(bus.busy), 0);
    repeat (4) @(posedge vclock); #1;

    // No pulses: zero position auto-scales to 4, rover stays on the baseline
    frame("idle1"); chk_rover("idle1", 4, 0, 256); restore_vsync();
    frame("idle2"); chk_rover("idle2", 4, 0, 256);
    chk("idle2_target_y", int'(bus.target_y), 256); restore_vsync();

    pulse(1, 30, 40, 0, 0);
    frame("loc"); chk_rover("loc", 4, 120, 416);
    chk("loc_oriented", int'(bus.oriented), 0); restore_vsync();

    pulse(1, -100, 100, 1, 7);
    frame("both"); chk_rover("both", 2, -200, 456);
    chk("both_orientation", int'(bus.orientation), 7);
    chk("both_oriented", int'(bus.oriented), 1); restore_vsync();

    bus.target_location = 4'b1110;
    pulse(1, 200, -10, 0, 0);
    frame("far"); chk_rover("far", 1, 200, 256);
    chk("far_target_x", int'(bus.target_x), -256);
    chk("far_target_y", int'(bus.target_y), 512); restore_vsync();

    // Last pulse wins; 64/64 is the inclusive edge of scale 4
    bus.target_location = 4'b0101;
    pulse(1, 10, 10, 0, 0);
    pulse(1, -64, 64, 0, 0);
    frame("edge64"); chk_rover("edge64", 4, -256, 512);
    chk("edge64_target_x", int'(bus.target_x), 0);
    chk("edge64_target_y", int'(bus.target_y), 320); restore_vsync();

    pulse(1, 65, 0, 0, 0);
    frame("edge65"); chk_rover("edge65", 2, 130, 256); restore_vsync();

    // Orientation arriving on the snapshot cycle is deferred one frame
    @(posedge vclock); #1 bus.vsync = 1'b0;
    @(posedge vclock); #1 bus.orientation_ready = 1'b1; bus.orientation_in = 5'd9;
    @(posedge vclock); #1 bus.orientation_ready = 1'b0;
    wait_commit(lat);
    chk("snap_latency", lat, 3);
    chk("snap_orientation", int'(bus.orientation), 7);
    chk("snap_oriented", int'(bus.oriented), 0);
    restore_vsync();
    frame("defer"); chk("defer_orientation", int'(bus.orientation), 9);
    chk("defer_oriented", int'(bus.oriented), 1);
    chk_rover("defer", 2, 130, 256); restore_vsync();

    // Reset during MULT: no commit, everything back to reset values
    pulse(1, 5, 5, 0, 0);
    @(posedge vclock); #1 bus.vsync = 1'b0;
    repeat (3) @(posedge vclock);
    #1 reset = 1'b1;
    @(posedge vclock);
    @(negedge vclock);
    chk("midrst_commit", int'(bus.commit), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk_rover("midrst", 2, 0, 256);
    chk("midrst_oriented", int'(bus.oriented), 0);
    chk("midrst_orientation", int'(bus.orientation), 0);
    @(posedge vclock); #1 reset = 1'b0;
    restore_vsync();
    frame("post"); chk_rover("post", 4, 0, 256);
    chk("post_oriented", int'(bus.oriented), 0); restore_vsync();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
